cpuif_bus_arbiter: RTL and testbench

CPUIF_BUS_ARBITER -- requirements
Module: cpuif_bus_arbiter

---
 rtl/cpuif_bus_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/cpuif_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cpuif_bus_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpuif_bus_pkg.sv
// Shared types and constants for the CPU-interface register bus arbiter.
// Command widths here set the widths the arbiter is built for.
package cpuif_bus_pkg;

    localparam int CPUIF_ADDR_WIDTH = 3;
    localparam int CPUIF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                        is_wr;
        logic [CPUIF_ADDR_WIDTH-1:0] addr;
        logic [CPUIF_DATA_WIDTH-1:0] wr_data;
        logic [CPUIF_DATA_WIDTH-1:0] wr_biten;
    } bus_cmd_t;

    // Index reached by stepping 'offset' places past 'last' in a ring of n.
    function automatic int rr_next(input int last, input int offset, input int n);
        return (last + offset) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set bit of 'pending' strictly after
// 'last_grant', wrapping from N_REQ-1 back to 0.
module rr_arbiter
    import cpuif_bus_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int GW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [GW-1:0]    last_grant,
    output logic [GW-1:0]    grant,
    output logic             valid
);

    logic [GW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = GW'(rr_next(int'(last_grant), i, N_REQ));
            if (!valid && pending[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpuif_bus_arbiter.sv
// Shares one register bus among N_REQ requesters, one outstanding command each.
// Define CPUIF_BUS_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module cpuif_bus_arbiter
    import cpuif_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = CPUIF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = CPUIF_DATA_WIDTH,
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0]                 i_req,
    input  logic [N_REQ-1:0]                 i_req_is_wr,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0] i_addr,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0] i_wr_data,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0] i_wr_biten,
    output logic [N_REQ-1:0]                 o_rd_ack,
    output logic [N_REQ-1:0]                 o_rd_err,
    output logic [N_REQ-1:0]                 o_wr_ack,
    output logic [N_REQ-1:0]                 o_wr_err,
    output logic [N_REQ-1:0]                 o_req_drop,
    output logic [DATA_WIDTH-1:0]            o_rd_data,
    output logic                             o_bus_req,
    output logic                             o_bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]            o_bus_addr,
    output logic [DATA_WIDTH-1:0]            o_bus_wr_data,
    output logic [DATA_WIDTH-1:0]            o_bus_wr_biten,
    input  logic                             i_bus_rd_ack,
    input  logic                             i_bus_rd_err,
    input  logic [DATA_WIDTH-1:0]            i_bus_rd_data,
    input  logic                             i_bus_wr_ack,
    input  logic                             i_bus_wr_err,
    input  logic                             i_bus_req_stall_wr,
    input  logic                             i_bus_req_stall_rd
);

    localparam int GW = $clog2(N_REQ);

    // Command slots are bus_cmd_t, so the bus widths must match the package.
    if (ADDR_WIDTH != CPUIF_ADDR_WIDTH || DATA_WIDTH != CPUIF_DATA_WIDTH ||
        N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cpuif_bus_arbiter: unsupported parameter combination");
    end

    arb_state_e       state;
    logic [GW-1:0]    grant;
    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    next_grant;
    logic             next_valid;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] complete;
    logic [N_REQ-1:0] accept;
    bus_cmd_t         slot [N_REQ];
    bus_cmd_t         cur;
    logic             active;
    logic             stalled;
    logic             ack_match;
    logic             err_match;
    logic             issue_now;
    logic             done;
    logic             timeout_fire;

    rr_arbiter #(
        .N_REQ(N_REQ),
        .GW   (GW)
    ) u_rr (
        .pending   (pending),
        .last_grant(last_grant),
        .grant     (next_grant),
        .valid     (next_valid)
    );

    assign cur       = slot[grant];
    assign active    = !rst && (state != IDLE);
    assign stalled   = cur.is_wr ? i_bus_req_stall_wr : i_bus_req_stall_rd;
    assign ack_match = cur.is_wr ? i_bus_wr_ack : i_bus_rd_ack;
    assign err_match = cur.is_wr ? i_bus_wr_err : i_bus_rd_err;
    assign issue_now = !rst && (state == ISSUE) && !stalled;

`ifdef CPUIF_BUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    // wait_cnt is 0 on the first WAIT cycle, so the limit is TIMEOUT_CYCLES-1.
    assign timeout_fire = !rst && (state == WAIT) && !ack_match &&
                          (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    assign done = (issue_now && ack_match) ||
                  (!rst && (state == WAIT) && ack_match) ||
                  timeout_fire;

    always_comb begin
        complete = '0;
        if (done) begin
            complete[grant] = 1'b1;
        end
    end

    // A slot can be refilled on the very cycle its previous command completes.
    assign accept     = i_req & (~pending | complete) & {N_REQ{!rst}};
    assign o_req_drop = i_req & pending & ~complete & {N_REQ{!rst}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            grant      <= '0;
            last_grant <= GW'(N_REQ - 1);
            for (int k = 0; k < N_REQ; k++) begin
                slot[k] <= '0;
            end
        end else begin
            pending <= (pending & ~complete) | accept;
            for (int k = 0; k < N_REQ; k++) begin
                if (accept[k]) begin
                    slot[k] <= '{is_wr:    i_req_is_wr[k],
                                 addr:     i_addr[k],
                                 wr_data:  i_wr_data[k],
                                 wr_biten: i_wr_biten[k]};
                end
            end
            if (done) begin
                last_grant <= grant;
            end
            unique case (state)
                IDLE: begin
                    if (next_valid) begin
                        grant <= next_grant;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stalled) begin
                        state <= ack_match ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (ack_match || timeout_fire) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_rd_ack  = '0;
        o_rd_err  = '0;
        o_wr_ack  = '0;
        o_wr_err  = '0;
        o_rd_data = (rst || timeout_fire) ? '0 : i_bus_rd_data;
        if (done) begin
            if (cur.is_wr) begin
                o_wr_ack[grant] = 1'b1;
                o_wr_err[grant] = err_match | timeout_fire;
            end else begin
                o_rd_ack[grant] = 1'b1;
                o_rd_err[grant] = err_match | timeout_fire;
            end
        end
    end

    assign o_bus_req       = issue_now;
    assign o_bus_req_is_wr = active && cur.is_wr;
    assign o_bus_addr      = active ? cur.addr     : '0;
    assign o_bus_wr_data   = active ? cur.wr_data  : '0;
    assign o_bus_wr_biten  = active ? cur.wr_biten : '0;

endmodule

// File: tb/tb_cpuif_bus_arbiter.sv
// Bench for cpuif_bus_arbiter: directed scenarios then random traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_cpuif_bus_arbiter;

    localparam int N   = 2;
    localparam int AW  = 3;
    localparam int DW  = 32;
    localparam int TMO = 8;
`ifdef CPUIF_BUS_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0]             req;
    logic [N-1:0]             req_is_wr;
    logic [N-1:0][AW-1:0]     addr;
    logic [N-1:0][DW-1:0]     wr_data;
    logic [N-1:0][DW-1:0]     wr_biten;
    logic [N-1:0]             rd_ack;
    logic [N-1:0]             rd_err;
    logic [N-1:0]             wr_ack;
    logic [N-1:0]             wr_err;
    logic [N-1:0]             req_drop;
    logic [DW-1:0]            rd_data;
    logic                     bus_req;
    logic                     bus_req_is_wr;
    logic [AW-1:0]            bus_addr;
    logic [DW-1:0]            bus_wr_data;
    logic [DW-1:0]            bus_wr_biten;
    logic                     bus_rd_ack;
    logic                     bus_rd_err;
    logic [DW-1:0]            bus_rd_data;
    logic                     bus_wr_ack;
    logic                     bus_wr_err;
    logic                     stall_wr;
    logic                     stall_rd;

    cpuif_bus_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .N_REQ         (N),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_req             (req),
        .i_req_is_wr       (req_is_wr),
        .i_addr            (addr),
        .i_wr_data         (wr_data),
        .i_wr_biten        (wr_biten),
        .o_rd_ack          (rd_ack),
        .o_rd_err          (rd_err),
        .o_wr_ack          (wr_ack),
        .o_wr_err          (wr_err),
        .o_req_drop        (req_drop),
        .o_rd_data         (rd_data),
        .o_bus_req         (bus_req),
        .o_bus_req_is_wr   (bus_req_is_wr),
        .o_bus_addr        (bus_addr),
        .o_bus_wr_data     (bus_wr_data),
        .o_bus_wr_biten    (bus_wr_biten),
        .i_bus_rd_ack      (bus_rd_ack),
        .i_bus_rd_err      (bus_rd_err),
        .i_bus_rd_data     (bus_rd_data),
        .i_bus_wr_ack      (bus_wr_ack),
        .i_bus_wr_err      (bus_wr_err),
        .i_bus_req_stall_wr(stall_wr),
        .i_bus_req_stall_rd(stall_rd)
    );

    always #5 clk = ~clk;

    // Model: per-requester queued command, the owner of the bus (-1 when free),
    // whether the owner's request has gone out, and how long it has waited.
    bit            m_pend  [N];
    bit            m_wr    [N];
    logic [AW-1:0] m_addr  [N];
    logic [DW-1:0] m_wdata [N];
    logic [DW-1:0] m_biten [N];
    int            m_owner  = -1;
    bit            m_issued = 1'b0;
    int            m_waited = 0;
    int            m_last   = N - 1;

    logic          e_bus_req, e_is_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_biten, e_rd_data;
    logic [N-1:0]  e_rd_ack, e_rd_err, e_wr_ack, e_wr_err, e_drop;
    bit            e_done;

    int n_checks = 0;
    int n_fail   = 0;
    int order[$];

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_eval();
        bit w, ack, err, stall;
        e_bus_req = 1'b0; e_is_wr = 1'b0; e_addr = '0; e_wdata = '0; e_biten = '0;
        e_rd_data = '0; e_rd_ack = '0; e_rd_err = '0; e_wr_ack = '0; e_wr_err = '0;
        e_drop = '0; e_done = 1'b0;
        if (rst) return;
        e_rd_data = bus_rd_data;
        if (m_owner >= 0) begin
            w       = m_wr[m_owner];
            e_is_wr = w;
            e_addr  = m_addr[m_owner];
            e_wdata = m_wdata[m_owner];
            e_biten = m_biten[m_owner];
            ack     = w ? bus_wr_ack : bus_rd_ack;
            err     = w ? bus_wr_err : bus_rd_err;
            stall   = w ? stall_wr : stall_rd;
            if (!m_issued) begin
                if (!stall) begin
                    e_bus_req = 1'b1;
                    e_done    = ack;
                end
            end else if (ack) begin
                e_done = 1'b1;
            end else if (TMO_EN && (m_waited + 1 == TMO)) begin
                e_done    = 1'b1;
                err       = 1'b1;
                e_rd_data = '0;
            end
            if (e_done) begin
                if (w) begin
                    e_wr_ack[m_owner] = 1'b1;
                    e_wr_err[m_owner] = err;
                end else begin
                    e_rd_ack[m_owner] = 1'b1;
                    e_rd_err[m_owner] = err;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            e_drop[k] = req[k] && m_pend[k] && !(e_done && m_owner == k);
        end
    endtask

    task automatic model_update();
        bit old_pend [N];
        int done_idx;
        if (rst) begin
            m_pend   = '{default: 1'b0};
            m_owner  = -1;
            m_issued = 1'b0;
            m_waited = 0;
            m_last   = N - 1;
            return;
        end
        old_pend = m_pend;
        done_idx = e_done ? m_owner : -1;
        if (e_done) begin
            m_pend[m_owner] = 1'b0;
            m_last  = m_owner;
            m_owner = -1;
        end else if (m_owner >= 0) begin
            if (!m_issued) begin
                if (e_bus_req) begin
                    m_issued = 1'b1;
                    m_waited = 0;
                end
            end else begin
                m_waited++;
            end
        end else begin
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_last + i) % N;
                if (old_pend[c]) begin
                    m_owner  = c;
                    m_issued = 1'b0;
                    break;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (req[k] && (!old_pend[k] || done_idx == k)) begin
                m_pend[k]  = 1'b1;
                m_wr[k]    = req_is_wr[k];
                m_addr[k]  = addr[k];
                m_wdata[k] = wr_data[k];
                m_biten[k] = wr_biten[k];
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
        check_output("bus_req", bus_req, e_bus_req);
        check_output("bus_is_wr", bus_req_is_wr, e_is_wr);
        check_output("bus_addr", bus_addr, e_addr);
        check_output("bus_wr_data", bus_wr_data, e_wdata);
        check_output("bus_wr_biten", bus_wr_biten, e_biten);
        check_output("rd_ack", rd_ack, e_rd_ack);
        check_output("rd_err", rd_err, e_rd_err);
        check_output("wr_ack", wr_ack, e_wr_ack);
        check_output("wr_err", wr_err, e_wr_err);
        check_output("req_drop", req_drop, e_drop);
        check_output("rd_data", rd_data, e_rd_data);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic clear_inputs();
        req = '0; req_is_wr = '0; addr = '0; wr_data = '0; wr_biten = '0;
        bus_rd_ack = 1'b0; bus_rd_err = 1'b0; bus_rd_data = '0;
        bus_wr_ack = 1'b0; bus_wr_err = 1'b0; stall_wr = 1'b0; stall_rd = 1'b0;
    endtask

    task automatic pulse(input int k, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] be);
        req[k] = 1'b1; req_is_wr[k] = w; addr[k] = a; wr_data[k] = d; wr_biten[k] = be;
    endtask

    task automatic apply_stimulus();
        for (int k = 0; k < N; k++) begin
            req[k]       = ($urandom_range(0, 99) < 25);
            req_is_wr[k] = $urandom_range(0, 1) == 1;
            addr[k]      = AW'($urandom);
            wr_data[k]   = $urandom;
            wr_biten[k]  = $urandom;
        end
        bus_rd_ack  = ($urandom_range(0, 99) < 30);
        bus_wr_ack  = ($urandom_range(0, 99) < 30);
        bus_rd_err  = ($urandom_range(0, 99) < 20);
        bus_wr_err  = ($urandom_range(0, 99) < 20);
        stall_rd    = ($urandom_range(0, 99) < 25);
        stall_wr    = ($urandom_range(0, 99) < 25);
        bus_rd_data = $urandom;
        rst         = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        // Reset with noisy inputs: every output must stay 0.
        rst = 1'b1;
        clear_inputs();
        req = '1; bus_rd_ack = 1'b1; bus_wr_ack = 1'b1; bus_rd_data = 32'hFFFF_FFFF;
        settle();
        check_output("rst_rd_data", rd_data, 0);
        check_output("rst_drop", req_drop, 0);
        advance();
        cycle();
        rst = 1'b0;
        clear_inputs();
        cycle();

        // Contention: both requesters every round, reads acked in ISSUE.
        bus_rd_ack = 1'b1; bus_rd_data = 32'h1234_5678;
        for (int r = 0; r < 3; r++) begin
            pulse(0, 1'b0, 3'd1, '0, '0);
            pulse(1, 1'b0, 3'd2, '0, '0);
            cycle();
            req = '0;
            repeat (6) begin
                settle();
                if (rd_ack[0]) order.push_back(0);
                else if (rd_ack[1]) order.push_back(1);
                advance();
            end
        end
        bus_rd_ack = 1'b0;
        check_output("rr_count", order.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_output("rr_order", (i < order.size()) ? order[i] : 99, i % 2);
        end

        // Single read from requester 0, address 3: bus request two edges later.
        pulse(0, 1'b0, 3'd3, '0, '0);
        cycle();
        req = '0;
        settle(); check_output("lat_n1_bus_req", bus_req, 0); advance();
        settle();
        check_output("lat_n2_bus_req", bus_req, 1);
        check_output("lat_addr", bus_addr, 3);
        advance();
        settle(); check_output("wait_bus_req", bus_req, 0); advance();
        bus_rd_ack = 1'b1; bus_rd_data = 32'hDEAD_BEEF;
        settle();
        check_output("single_rd_ack0", rd_ack[0], 1);
        check_output("single_rd_ack1", rd_ack[1], 0);
        check_output("single_rd_data", rd_data, 32'hDEAD_BEEF);
        advance();
        clear_inputs();
        cycle();

        // Stalled write: held off for five cycles, stray ack ignored.
        stall_wr = 1'b1;
        pulse(0, 1'b1, 3'd5, 32'hA5A5_0F0F, 32'h0000_FFFF);
        cycle();
        req = '0;
        cycle();
        bus_wr_ack = 1'b1;
        repeat (5) begin
            settle();
            check_output("stall_bus_req", bus_req, 0);
            check_output("stall_wr_ack", wr_ack, 0);
            advance();
        end
        stall_wr = 1'b0; bus_wr_ack = 1'b0;
        settle();
        check_output("unstall_bus_req", bus_req, 1);
        check_output("unstall_wdata", bus_wr_data, 32'hA5A5_0F0F);
        check_output("unstall_biten", bus_wr_biten, 32'h0000_FFFF);
        advance();
        bus_wr_ack = 1'b1; bus_wr_err = 1'b1;
        settle();
        check_output("stall_done_ack", wr_ack, 2'b01);
        check_output("stall_done_err", wr_err, 2'b01);
        advance();
        clear_inputs();
        cycle();

        // Drop while pending, then back-to-back refill on the completion cycle.
        pulse(1, 1'b0, 3'd4, '0, '0);
        cycle();
        pulse(1, 1'b0, 3'd7, '0, '0);
        settle(); check_output("drop_pulse", req_drop, 2'b10); advance();
        req = '0;
        settle();
        check_output("drop_once", req_drop, 0);
        check_output("drop_kept_addr", bus_addr, 4);
        advance();
        pulse(1, 1'b0, 3'd6, '0, '0);
        bus_rd_ack = 1'b1; bus_rd_data = 32'h0BAD_F00D;
        settle();
        check_output("b2b_ack", rd_ack, 2'b10);
        check_output("b2b_no_drop", req_drop, 0);
        advance();
        req = '0; bus_rd_ack = 1'b0;
        cycle();
        settle();
        check_output("b2b_issue", bus_req, 1);
        check_output("b2b_addr", bus_addr, 6);
        advance();
        bus_rd_ack = 1'b1;
        cycle();
        bus_rd_ack = 1'b0;
        cycle();

        // Read that is never acked.
        pulse(0, 1'b0, 3'd2, '0, '0);
        cycle();
        req = '0;
        cycle();
        bus_rd_data = 32'hCAFE_0001;
        settle(); check_output("tmo_issue", bus_req, 1); advance();
`ifdef CPUIF_BUS_ARB_TIMEOUT_EN
        repeat (TMO - 1) begin
            settle(); check_output("tmo_early", rd_ack, 0); advance();
        end
        settle();
        check_output("tmo_ack", rd_ack, 2'b01);
        check_output("tmo_err", rd_err, 2'b01);
        check_output("tmo_data", rd_data, 0);
        advance();
        settle(); check_output("tmo_idle", bus_addr, 0); advance();
`else
        repeat (100) begin
            settle(); check_output("no_tmo_ack", rd_ack, 0); advance();
        end
        settle(); check_output("no_tmo_hold", bus_addr, 2); advance();
        bus_rd_ack = 1'b1;
        settle();
        check_output("late_ack", rd_ack, 2'b01);
        check_output("late_data", rd_data, 32'hCAFE_0001);
        advance();
        bus_rd_ack = 1'b0;
        cycle();
`endif

        // Reset in WAIT: no ack escapes, requester 0 wins first afterwards.
        pulse(1, 1'b1, 3'd3, 32'h1111_2222, 32'hFFFF_FFFF);
        cycle();
        req = '0;
        cycle();
        cycle();
        rst = 1'b1; bus_wr_ack = 1'b1;
        settle();
        check_output("rst_mid_wr_ack", wr_ack, 0);
        check_output("rst_mid_addr", bus_addr, 0);
        advance();
        rst = 1'b0; bus_wr_ack = 1'b0;
        settle(); check_output("post_rst_idle", bus_addr, 0); advance();
        pulse(0, 1'b0, 3'd1, '0, '0);
        pulse(1, 1'b0, 3'd7, '0, '0);
        cycle();
        req = '0;
        cycle();
        settle();
        check_output("post_rst_first_req", bus_req, 1);
        check_output("post_rst_first_addr", bus_addr, 1);
        advance();
        bus_rd_ack = 1'b1;
        repeat (6) cycle();
        clear_inputs();

        // Random traffic against the model.
        repeat (800) begin
            apply_stimulus();
            cycle();
        end
        clear_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
